data_memory: RTL and testbench

// - CPU-side 256x32 word data memory, write-through to external DDR3 via the codebase's memory-controller request port.
// - Local array plus per-word valid bits serves read hits in one cycle. Read misses fill from external memory.
// - Writes update the local array and are forwarded externally in order.
// - Sits between the CPU data port and the memory controller (mem_* handshake).

---
 rtl/data_memory.sv | 155 +++++++++++++++
 tb/tb_data_memory.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// 256x32 CPU data memory with per-word valid bits, write-through to an external controller.
// Optional write buffer: define DATA_MEMORY_WRITE_BUFFER_EN.
module data_memory #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 32,
  parameter logic [MEM_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int WBUF_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_WIDTH-1:0]     addr,
  output logic [DATA_WIDTH-1:0]     data_read,
  input  logic [DATA_WIDTH-1:0]     data_write,
  input  logic                      read_en,
  input  logic                      write_en,
  output logic                      busy,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic                      mem_read_en,
  output logic                      mem_write_en,
  input  logic [DATA_WIDTH-1:0]     mem_read_val,
  output logic [DATA_WIDTH-1:0]     mem_write_val,
  input  logic                      mem_response
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] FILL  = 2'd2;

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] mem_array [DEPTH];
  logic [DEPTH-1:0]      valid;
  logic [ADDR_WIDTH-1:0] fill_idx;
  logic                  miss, accept_wr, accept_rd, fill_done;
  logic                  wr_pending;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;

  function automatic logic [MEM_ADDR_WIDTH-1:0] ext_addr(input logic [ADDR_WIDTH-1:0] a);
    logic [MEM_ADDR_WIDTH-1:0] off;
    off = '0;
    off[ADDR_WIDTH+1:0] = {a, 2'b00};
    return BASE_ADDR + off;
  endfunction

  assign miss      = read_en && !write_en && !valid[addr];
  assign accept_wr = write_en && !busy;
  assign accept_rd = read_en && !write_en && !busy;
  assign fill_done = (state == FILL) && mem_response;

`ifdef DATA_MEMORY_WRITE_BUFFER_EN
  localparam int PW = $clog2(WBUF_DEPTH);
  logic [ADDR_WIDTH-1:0] fifo_idx  [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [WBUF_DEPTH];
  logic [PW:0]           wptr, rptr;
  logic                  full;

  assign full       = (wptr - rptr) == (PW+1)'(WBUF_DEPTH);
  assign wr_pending = wptr != rptr;
  assign wr_idx     = fifo_idx[rptr[PW-1:0]];
  assign wr_data    = fifo_data[rptr[PW-1:0]];

  // Writes only stall on a full buffer; a freed slot is visible the cycle after the pop.
  always_comb begin
    busy = 1'b0;
    if (state == FILL)  busy = !mem_response;
    else if (write_en)  busy = full;
    else                busy = miss;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (accept_wr) begin
        fifo_idx[wptr[PW-1:0]]  <= addr;
        fifo_data[wptr[PW-1:0]] <= data_write;
        wptr <= wptr + 1'b1;
      end
      if (state == WRITE && mem_response) rptr <= rptr + 1'b1;
    end
  end
`else
  // Unbuffered: the CPU write itself is the outstanding external write.
  assign wr_pending = write_en;
  assign wr_idx     = addr;
  assign wr_data    = data_write;

  always_comb begin
    busy = 1'b0;
    if (state != IDLE) busy = !mem_response;
    else               busy = write_en || miss;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      mem_read_en   <= 1'b0;
      mem_write_en  <= 1'b0;
      mem_addr      <= '0;
      mem_write_val <= '0;
      fill_idx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Pending writes drain before a fill so external order matches CPU order.
          if (wr_pending) begin
            state         <= WRITE;
            mem_write_en  <= 1'b1;
            mem_addr      <= ext_addr(wr_idx);
            mem_write_val <= wr_data;
          end else if (miss) begin
            state       <= FILL;
            mem_read_en <= 1'b1;
            mem_addr    <= ext_addr(addr);
            fill_idx    <= addr;
          end
        end
        WRITE: if (mem_response) begin
          state        <= IDLE;
          mem_write_en <= 1'b0;
        end
        FILL: if (mem_response) begin
          state       <= IDLE;
          mem_read_en <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid     <= '0;
      data_read <= '0;
    end else begin
      if (fill_done) begin
        valid[fill_idx] <= 1'b1;
        data_read       <= mem_read_val;
      end else if (accept_rd) begin
        data_read <= mem_array[addr];
      end
      if (accept_wr) valid[addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (fill_done) mem_array[fill_idx] <= mem_read_val;
      if (accept_wr) mem_array[addr]     <= data_write;
    end
  end
endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: CPU-side tasks plus a latency-programmable controller model.
module tb_data_memory;
  logic        clk = 1'b0, reset = 1'b1;
  logic [7:0]  addr = '0;
  logic [31:0] data_read, data_write = '0, mem_addr, mem_write_val, mem_read_val = '0;
  logic        read_en = 1'b0, write_en = 1'b0, busy;
  logic        mem_read_en, mem_write_en, mem_response = 1'b0;

  int n_checks = 0, n_errors = 0;
  int lat = 2, cnt = 0, cyc = 0, n_mem_rd = 0, last_wr_resp = -1, rd_rise = -1;
  int late_req = 0, late_done = 0;
  logic        stall = 1'b0, rd_prev = 1'b0;
  logic [31:0] rd_data = '0, last_rd_addr = '0;
  logic [31:0] wlog_addr [$];
  logic [31:0] wlog_data [$];

  data_memory dut (
    .clk(clk), .reset(reset), .addr(addr), .data_read(data_read), .data_write(data_write),
    .read_en(read_en), .write_en(write_en), .busy(busy), .mem_addr(mem_addr),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_read_val(mem_read_val),
    .mem_write_val(mem_write_val), .mem_response(mem_response)
  );

  always #5 clk = ~clk;

  // Controller: one-cycle response pulse lat cycles after the enable is seen.
  always @(negedge clk) begin
    cyc++;
    if (mem_read_en && !rd_prev) rd_rise = cyc;
    rd_prev = mem_read_en;
    if (mem_response) mem_response = 1'b0;
    else if (late_req != late_done) begin
      late_done    = late_req;
      mem_read_val = 32'hBAD0BAD0;
      mem_response = 1'b1;
    end else if ((mem_read_en || mem_write_en) && !stall) begin
      if (cnt == lat - 1) begin
        cnt = 0;
        mem_response = 1'b1;
        if (mem_write_en) begin
          wlog_addr.push_back(mem_addr);
          wlog_data.push_back(mem_write_val);
          last_wr_resp = cyc;
        end else begin
          mem_read_val = rd_data;
          last_rd_addr = mem_addr;
          n_mem_rd++;
        end
      end else cnt++;
    end else cnt = 0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic rd_too);
    int n = 0;
    @(negedge clk);
    addr = a; data_write = d; write_en = 1'b1; read_en = rd_too;
    #2;
    while (busy && n < 100) begin n++; @(negedge clk); #2; end
    if (busy) chk("wr_timeout", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic cpu_read(input logic [7:0] a, output logic [31:0] d, output int waits);
    waits = 0;
    @(negedge clk);
    addr = a; read_en = 1'b1; write_en = 1'b0;
    #2;
    while (busy && waits < 100) begin waits++; @(negedge clk); #2; end
    if (busy) chk("rd_timeout", 32'(busy), 32'd0);
    @(posedge clk); #1;
    d = data_read;
  endtask

  task automatic idle();
    @(negedge clk);
    read_en = 1'b0; write_en = 1'b0;
  endtask

  task automatic wait_quiet();
    int q = 0, n = 0;
    while (q < 4 && n < 500) begin
      @(negedge clk); #2; n++;
      if (mem_read_en || mem_write_en) q = 0; else q++;
    end
    if (q < 4) chk("quiet_timeout", {30'd0, mem_read_en, mem_write_en}, 32'd0);
  endtask

  task automatic chk_zero_outputs(input string pfx);
    chk({pfx, "_data_read"}, data_read, 32'd0);
    chk({pfx, "_busy"}, 32'(busy), 32'd0);
    chk({pfx, "_mem_read_en"}, 32'(mem_read_en), 32'd0);
    chk({pfx, "_mem_write_en"}, 32'(mem_write_en), 32'd0);
    chk({pfx, "_mem_addr"}, mem_addr, 32'd0);
    chk({pfx, "_mem_write_val"}, mem_write_val, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int w, rd_before, base;

    repeat (3) @(posedge clk);
    #1 chk_zero_outputs("reset");
    @(negedge clk) reset = 1'b0;

    // Write 0..7 with 1..8, then read them back as hits.
    lat = 2;
    for (int i = 0; i < 8; i++) cpu_write(8'(i), 32'(i + 1), 1'b0);
    idle(); wait_quiet();
    chk("wlog_count", 32'(wlog_addr.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < wlog_addr.size()) begin
        chk($sformatf("wlog_addr%0d", i), wlog_addr[i], 32'(i * 4));
        chk($sformatf("wlog_data%0d", i), wlog_data[i], 32'(i + 1));
      end
    for (int i = 0; i < 8; i++) begin
      cpu_read(8'(i), d, w);
      chk($sformatf("hit_data%0d", i), d, 32'(i + 1));
      chk($sformatf("hit_wait%0d", i), 32'(w), 32'd0);
    end
    chk("hit_no_ext_rd", 32'(n_mem_rd), 32'd0);

    // Cold miss at 0x20, then re-read hits.
    lat = 3; rd_data = 32'hDEADBEEF;
    cpu_read(8'h20, d, w);
    chk("miss_wait", 32'(w), 32'd3);
    chk("miss_data", d, 32'hDEADBEEF);
    chk("miss_mem_addr", last_rd_addr, 32'h80);
    chk("miss_ext_rd", 32'(n_mem_rd), 32'd1);
    cpu_read(8'h20, d, w);
    chk("rehit_data", d, 32'hDEADBEEF);
    chk("rehit_wait", 32'(w), 32'd0);
    chk("rehit_ext_rd", 32'(n_mem_rd), 32'd1);

    // Simultaneous read+write: write wins, data_read holds.
    cpu_write(8'd3, 32'h55, 1'b1);
    idle();
    chk("simul_hold", data_read, 32'hDEADBEEF);
    wait_quiet();
    chk("simul_wlog_addr", wlog_addr[$], 32'h0C);
    chk("simul_wlog_data", wlog_data[$], 32'h55);
    cpu_read(8'd3, d, w);
    chk("simul_data", d, 32'h55);

    // Miss after write: fill must follow the write's response.
    rd_rise = -1; rd_data = 32'h1010;
    cpu_write(8'd9, 32'h99, 1'b0);
    cpu_read(8'd10, d, w);
    idle();
    chk("order_rd_after_wr", 32'(rd_rise > last_wr_resp), 32'd1);
    chk("order_wr_addr", wlog_addr[$], 32'h24);
    chk("order_rd_data", d, 32'h1010);
    wait_quiet();

    // Reset in the middle of a fill.
    stall = 1'b1;
    @(negedge clk);
    addr = 8'h30; read_en = 1'b1; write_en = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("fill_rd_en", 32'(mem_read_en), 32'd1);
    chk("fill_addr", mem_addr, 32'hC0);
    chk("fill_busy", 32'(busy), 32'd1);
    @(negedge clk); reset = 1'b1; read_en = 1'b0;
    @(negedge clk); reset = 1'b0;
    #1 chk_zero_outputs("rst_fill");
    late_req = 1; stall = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("late_data_read", data_read, 32'd0);
    chk("late_rd_en", 32'(mem_read_en), 32'd0);
    rd_before = n_mem_rd; rd_data = 32'h3030;
    cpu_read(8'h30, d, w);
    chk("remiss_wait", 32'(w), 32'd3);
    chk("remiss_data", d, 32'h3030);
    chk("remiss_ext_rd", 32'(n_mem_rd - rd_before), 32'd1);
    rd_data = 32'hA0;
    cpu_read(8'h00, d, w);
    chk("cleared_wait", 32'(w), 32'd3);
    chk("cleared_data", d, 32'hA0);
    idle(); wait_quiet();

`ifdef DATA_MEMORY_WRITE_BUFFER_EN
    // Five writes against a stalled controller: the fifth sees a full buffer.
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      addr = 8'(8'h40 + i); data_write = 32'(32'h100 + i); write_en = 1'b1; read_en = 1'b0;
      #2 chk($sformatf("wbuf_busy%0d", i), 32'(busy), 32'(i == 4));
      if (i < 4) @(posedge clk);
    end
    stall = 1'b0;
    w = 0;
    while (busy && w < 100) begin w++; @(negedge clk); #2; end
    chk("wbuf_accept", 32'(busy), 32'd0);
    @(posedge clk); #1;
    idle(); wait_quiet();
    base = wlog_addr.size() - 5;
    for (int i = 0; i < 5; i++)
      if (base + i >= 0) begin
        chk($sformatf("wbuf_addr%0d", i), wlog_addr[base + i], 32'(32'h100 + 4 * i));
        chk($sformatf("wbuf_data%0d", i), wlog_data[base + i], 32'(32'h100 + i));
      end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
